// File: rtl/fetcher.sv
// Instruction fetch unit with a one-entry instruction buffer, bounded memory wait and a sticky
// timeout flag. Warp phases and fetcher states use the encodings given by the localparams below.
module fetcher #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [2:0]            i_warp_state,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  input  logic                  i_flush,
  output logic                  o_mem_read_valid,
  output logic [ADDR_WIDTH-1:0] o_mem_read_address,
  input  logic                  i_mem_read_ready,
  input  logic [31:0]           i_mem_read_data,
  output logic [31:0]           o_instruction,
  output logic [1:0]            o_fetcher_state,
  output logic                  o_fetch_error
);

  localparam logic [2:0] WARP_FETCH  = 3'd1;
  localparam logic [2:0] WARP_DECODE = 3'd2;
  localparam logic [2:0] OPCODE_HALT = 3'b111;

  localparam int unsigned CntW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    FetcherIdle     = 2'd0,
    FetcherFetching = 2'd1,
    FetcherDone     = 2'd2
  } fetcher_state_e;

  fetcher_state_e        r_state, w_state_d;
  logic                  r_valid, w_valid_d;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
  logic [31:0]           r_instr, w_instr_d;
  logic                  r_err, w_err_d;
  logic                  r_buf_valid, w_buf_valid_d;
  logic [ADDR_WIDTH-1:0] r_buf_pc, w_buf_pc_d;
  logic [31:0]           r_buf_instr, w_buf_instr_d;
  logic [CntW-1:0]       r_cnt, w_cnt_d;

  logic            w_fetch_req;
  logic            w_hit;
  logic [CntW-1:0] w_cnt_inc;
  logic            w_timeout;

  assign w_fetch_req = (i_warp_state == WARP_FETCH);
  assign w_hit       = r_buf_valid && (r_buf_pc == i_pc) && !i_flush;
  assign w_cnt_inc   = r_cnt + 1'b1;
  // Ready arriving on the final wait cycle takes priority over the abort.
  assign w_timeout   = (r_state == FetcherFetching) && !i_mem_read_ready && (w_cnt_inc == CntLast);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= FetcherIdle;
      r_valid     <= 1'b0;
      r_addr      <= '0;
      r_instr     <= '0;
      r_err       <= 1'b0;
      r_buf_valid <= 1'b0;
      r_buf_pc    <= '0;
      r_buf_instr <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_d;
      r_valid     <= w_valid_d;
      r_addr      <= w_addr_d;
      r_instr     <= w_instr_d;
      r_err       <= w_err_d;
      r_buf_valid <= w_buf_valid_d;
      r_buf_pc    <= w_buf_pc_d;
      r_buf_instr <= w_buf_instr_d;
      r_cnt       <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      FetcherIdle:     if (w_fetch_req) w_state_d = w_hit ? FetcherDone : FetcherFetching;
      FetcherFetching: if (i_mem_read_ready || w_timeout) w_state_d = FetcherDone;
      FetcherDone:     if (i_warp_state == WARP_DECODE) w_state_d = FetcherIdle;
      default:         w_state_d = FetcherIdle;
    endcase
  end

  always_comb begin
    w_valid_d     = r_valid;
    w_addr_d      = r_addr;
    w_instr_d     = r_instr;
    w_err_d       = r_err;
    w_buf_valid_d = r_buf_valid && !i_flush;
    w_buf_pc_d    = r_buf_pc;
    w_buf_instr_d = r_buf_instr;
    w_cnt_d       = r_cnt;
    unique case (r_state)
      FetcherIdle: begin
        if (w_fetch_req) begin
          if (w_hit) begin
            w_instr_d = r_buf_instr;
          end else begin
            w_valid_d = 1'b1;
            w_addr_d  = i_pc;
            w_cnt_d   = '0;
          end
        end
      end
      FetcherFetching: begin
        if (i_mem_read_ready) begin
          w_valid_d     = 1'b0;
          w_instr_d     = i_mem_read_data;
          w_buf_pc_d    = r_addr;
          w_buf_instr_d = i_mem_read_data;
          w_buf_valid_d = !i_flush;
        end else begin
          w_cnt_d = w_cnt_inc;
          if (w_timeout) begin
            w_valid_d = 1'b0;
            w_instr_d = {OPCODE_HALT, 29'b0};
            w_err_d   = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign o_mem_read_valid   = r_valid;
  assign o_mem_read_address = r_addr;
  assign o_instruction      = r_instr;
  assign o_fetcher_state    = r_state;
  assign o_fetch_error      = r_err;

endmodule

// File: tb/tb_fetcher.sv
// Randomized self-checking bench for fetcher: a transaction-level model predicts hit/miss,
// request length, delivered word and the sticky error flag for every fetch.
module tb_fetcher;

  localparam int unsigned T = 4;
  localparam logic [2:0] WIdle = 3'd0, WFetch = 3'd1, WDecode = 3'd2;
  localparam logic [1:0] SIdle = 2'd0, SFetching = 2'd1, SDone = 2'd2;
  localparam logic [31:0] Halt = 32'hE000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  warp;
  logic [31:0] pc;
  logic        flush;
  logic        valid;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;
  logic [31:0] instr;
  logic [1:0]  state;
  logic        err;

  always #5 clk = ~clk;

  fetcher #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_warp_state       (warp),
    .i_pc               (pc),
    .i_flush            (flush),
    .o_mem_read_valid   (valid),
    .o_mem_read_address (addr),
    .i_mem_read_ready   (ready),
    .i_mem_read_data    (rdata),
    .o_instruction      (instr),
    .o_fetcher_state    (state),
    .o_fetch_error      (err)
  );

  int n_checks = 0;
  int n_bad    = 0;

  // Reference model: buffer contents and sticky error.
  logic        m_valid = 1'b0;
  logic [31:0] m_pc    = '0;
  logic [31:0] m_instr = '0;
  logic        m_err   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // fmode: 1 = flush on the lookup edge, 2 = flush on the response edge, else none.
  task automatic do_fetch(input logic [31:0] fpc, input int lat, input logic [31:0] data,
                          input int fmode);
    logic        hit;
    logic [31:0] exp_instr;
    int          exp_nv;
    int          nv;
    bit          done;
    bit          addr_ok;
    hit = m_valid && (m_pc == fpc) && (fmode != 1);
    if (fmode == 1) m_valid = 1'b0;
    if (hit) begin
      exp_instr = m_instr;
      exp_nv    = 0;
    end else if (lat < int'(T)) begin
      exp_instr = data;
      exp_nv    = lat + 1;
      m_pc      = fpc;
      m_instr   = data;
      m_valid   = (fmode != 2);
    end else begin
      exp_instr = Halt;
      exp_nv    = T;
      m_err     = 1'b1;
    end
    warp  = WFetch;
    pc    = fpc;
    flush = (fmode == 1);
    tick();
    flush = 1'b0;
    check("enter_state", state, hit ? SDone : SFetching);
    nv      = 0;
    addr_ok = 1'b1;
    done    = (state != SFetching);
    for (int c = 0; c < 3 * int'(T) + 8 && !done; c++) begin
      if (valid) begin
        nv++;
        if (addr !== fpc) addr_ok = 1'b0;
      end
      if (c == lat) begin
        ready = 1'b1;
        rdata = data;
        if (fmode == 2) flush = 1'b1;
      end
      tick();
      ready = 1'b0;
      flush = 1'b0;
      rdata = $urandom;
      done  = (state != SFetching);
    end
    check("fetch_bound", 32'(done), 32'd1);
    check("valid_cycles", nv, exp_nv);
    check("req_addr", 32'(addr_ok), 32'd1);
    check("done_state", state, SDone);
    check("done_valid", valid, 1'b0);
    check("instr", instr, exp_instr);
    check("fetch_error", err, m_err);
    pc = $urandom;
    tick();
    check("hold_state", state, SDone);
    check("hold_instr", instr, exp_instr);
    warp = WDecode;
    tick();
    check("decode_idle", state, SIdle);
    warp = WIdle;
  endtask

  // Idle cycles with stray ready pulses and occasional flushes.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      warp  = ($urandom_range(0, 1) == 0) ? WIdle : 3'($urandom_range(3, 7));
      ready = 1'($urandom_range(0, 1));
      rdata = $urandom;
      flush = ($urandom_range(0, 4) == 0);
      if (flush) m_valid = 1'b0;
      tick();
      ready = 1'b0;
      flush = 1'b0;
      check("idle_state", state, SIdle);
      check("idle_valid", valid, 1'b0);
      check("idle_error", err, m_err);
    end
    warp = WIdle;
  endtask

  logic [31:0] pcs [4];

  initial begin
    pcs[0] = 32'h40; pcs[1] = 32'h44; pcs[2] = 32'h80; pcs[3] = 32'h100;
    reset = 1'b0; warp = WIdle; pc = '0; flush = 1'b0; ready = 1'b0; rdata = '0;
    tick();
    tick();
    check("rst_state", state, SIdle);
    check("rst_valid", valid, 1'b0);
    check("rst_addr", addr, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_error", err, 1'b0);
    reset = 1'b1;
    tick();

    do_fetch(32'h40, 2, 32'h1234_5678, 0);
    do_fetch(32'h40, 0, 32'hDEAD_BEEF, 0);
    flush = 1'b1;
    tick();
    flush   = 1'b0;
    m_valid = 1'b0;
    do_fetch(32'h40, 1, 32'hCAFE_F00D, 0);
    do_fetch(32'h44, 3, 32'hA5A5_A5A5, 0);
    do_fetch(32'h48, 20, 32'h1111_2222, 0);
    do_fetch(32'h44, 0, 32'h0, 0);
    idle_cycles(3);

    for (int i = 0; i < 30; i++) begin
      do_fetch(pcs[$urandom_range(0, 3)], $urandom_range(0, 6), $urandom,
               $urandom_range(0, 5));
      idle_cycles($urandom_range(0, 2));
    end

    // Reset in the middle of an outstanding request.
    warp = WFetch;
    pc   = 32'h300;
    tick();
    check("mid_enter", state, SFetching);
    tick();
    reset = 1'b0;
    tick();
    warp  = WIdle;
    reset = 1'b1;
    m_valid = 1'b0;
    m_err   = 1'b0;
    check("mid_rst_state", state, SIdle);
    check("mid_rst_valid", valid, 1'b0);
    check("mid_rst_instr", instr, 32'd0);
    check("mid_rst_error", err, 1'b0);
    ready = 1'b1;
    rdata = 32'h7777_7777;
    tick();
    ready = 1'b0;
    check("late_ready_state", state, SIdle);
    check("late_ready_valid", valid, 1'b0);
    check("late_ready_instr", instr, 32'd0);
    do_fetch(32'h44, 1, 32'h5555_AAAA, 0);

    for (int i = 0; i < 20; i++) begin
      do_fetch(pcs[$urandom_range(0, 3)], $urandom_range(0, 6), $urandom,
               $urandom_range(0, 5));
      idle_cycles($urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
